// File: rtl/twos_comp_pkg.sv
// Shared definitions for the two's-complement negation controller.
// Holds the FSM state encoding and the counter-width helper used by
// twos_comp_ctrl to size its bit counter.
package twos_comp_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Bits needed to count bit positions 0..w-1 (w >= 2).
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_neg_core.sv
// Mealy bit-serial two's-complement negator.
// Bits arrive LSB first; every bit up to and including the first 1 passes
// through unchanged, every later bit is inverted.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-low reset
//   clr  - synchronous clear of the seen_one flag (start of a word)
//   en   - a valid operand bit is on din this cycle
//   din  - operand bit
//   dout - negated bit (combinational from din and seen_one)
module serial_neg_core (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic din,
    output logic dout
);

    logic seen_one;

    // Remembers whether a 1 has already gone past in the current word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seen_one <= 1'b0;
        end else if (clr) begin
            seen_one <= 1'b0;
        end else if (en && din) begin
            seen_one <= 1'b1;
        end
    end

    assign dout = seen_one ? ~din : din;

endmodule

// File: rtl/twos_comp_ctrl.sv
// Word-level controller around a bit-serial two's-complement negator.
// Accepts a WIDTH-bit operand, streams it LSB first through
// serial_neg_core, collects the negated bits and presents the result
// until the consumer takes it.
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   in_valid/in_ready   - operand handshake (ready only in IDLE)
//   in_data             - operand
//   out_valid/out_ready - result handshake (valid only in DONE)
//   out_data            - -in_data mod 2^WIDTH
//   busy                - word in flight (SHIFT or DONE)
//   ovf                 - only with TWOS_COMP_CTRL_OVF_EN: operand was the
//                         most negative value, valid with out_valid
module twos_comp_ctrl
    import twos_comp_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
`ifdef TWOS_COMP_CTRL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [WIDTH-1:0] opnd, opnd_nx;
    logic [WIDTH-1:0] res_nx;
    logic             in_ready_nx, out_valid_nx, busy_nx;
    logic             core_clr_c, core_en_c, core_dout_c;

`ifdef TWOS_COMP_CTRL_OVF_EN
    logic ovf_pend, ovf_pend_nx, ovf_nx;
`endif

    serial_neg_core u_core (
        .clk  (clk),
        .rst  (rst),
        .clr  (core_clr_c),
        .en   (core_en_c),
        .din  (opnd[0]),
        .dout (core_dout_c)
    );

    // State and datapath registers; outputs are registered from next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            opnd      <= '0;
            out_data  <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef TWOS_COMP_CTRL_OVF_EN
            ovf_pend  <= 1'b0;
            ovf       <= 1'b0;
`endif
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            opnd      <= opnd_nx;
            out_data  <= res_nx;
            in_ready  <= in_ready_nx;
            out_valid <= out_valid_nx;
            busy      <= busy_nx;
`ifdef TWOS_COMP_CTRL_OVF_EN
            ovf_pend  <= ovf_pend_nx;
            ovf       <= ovf_nx;
`endif
        end
    end

    // Next-state, datapath and output decode.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        opnd_nx    = opnd;
        res_nx     = out_data;
        core_clr_c = 1'b0;
        core_en_c  = 1'b0;
`ifdef TWOS_COMP_CTRL_OVF_EN
        ovf_pend_nx = ovf_pend;
`endif

        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    opnd_nx    = in_data;
                    cnt_nx     = '0;
                    core_clr_c = 1'b1;
                    state_nx   = ST_SHIFT;
`ifdef TWOS_COMP_CTRL_OVF_EN
                    ovf_pend_nx = (in_data == MIN_NEG);
`endif
                end
            end
            ST_SHIFT: begin
                // Negated bit enters at the MSB; after WIDTH shifts the
                // first bit processed sits at bit 0.
                core_en_c = 1'b1;
                res_nx    = {core_dout_c, out_data[WIDTH-1:1]};
                opnd_nx   = opnd >> 1;
                if (cnt == CW'(WIDTH - 1)) begin
                    cnt_nx   = '0;
                    state_nx = ST_DONE;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        in_ready_nx  = (state_nx == ST_IDLE);
        out_valid_nx = (state_nx == ST_DONE);
        busy_nx      = (state_nx != ST_IDLE);
`ifdef TWOS_COMP_CTRL_OVF_EN
        ovf_nx       = (state_nx == ST_DONE) ? ovf_pend_nx : 1'b0;
`endif
    end

endmodule

// File: tb/tb_twos_comp_ctrl.sv
// Self-checking bench for twos_comp_ctrl (WIDTH = 8). Define
// TWOS_COMP_CTRL_OVF_EN for both RTL and bench to exercise the ovf port.
module tb_twos_comp_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         busy;
`ifdef TWOS_COMP_CTRL_OVF_EN
    logic         ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    twos_comp_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
`ifdef TWOS_COMP_CTRL_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] din;
        logic [W-1:0] exp_res;
        logic         exp_ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Send one word, then wait (bounded) for out_valid. lat = edges after accept.
    task automatic run_word(input logic [W-1:0] d, input logic ordy,
                            output logic [W-1:0] res, output int lat, output logic o);
        int k;
        k = 0;
        while (!in_ready && k < 50) begin
            step();
            k++;
        end
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = ordy;
        step();
        in_valid = 1'b0;
        in_data  = W'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        res = out_data;
`ifdef TWOS_COMP_CTRL_OVF_EN
        o = ovf;
`else
        o = 1'b0;
`endif
    endtask

    function automatic logic [W-1:0] ref_neg(input int x);
        return W'((256 - x) % 256);
    endfunction

    vec_t         vecs[5];
    logic [W-1:0] res;
    int           lat;
    logic         o;

    initial begin
        vecs[0] = '{din: 8'h0B, exp_res: 8'hF5, exp_ovf: 1'b0};
        vecs[1] = '{din: 8'h00, exp_res: 8'h00, exp_ovf: 1'b0};
        vecs[2] = '{din: 8'h01, exp_res: 8'hFF, exp_ovf: 1'b0};
        vecs[3] = '{din: 8'h7F, exp_res: 8'h81, exp_ovf: 1'b0};
        vecs[4] = '{din: 8'h80, exp_res: 8'h80, exp_ovf: 1'b1};

        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        rst       = 1'b1;
        #1 rst = 1'b0;
        #20;
        check("reset_in_ready",  32'(in_ready),  32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_busy",      32'(busy),      32'd0);
        check("reset_out_data",  32'(out_data),  32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Directed vectors with out_ready high.
        for (int i = 0; i < 5; i++) begin
            run_word(vecs[i].din, 1'b1, res, lat, o);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
            check($sformatf("vec%0d_data", i), 32'(res), 32'(vecs[i].exp_res));
`ifdef TWOS_COMP_CTRL_OVF_EN
            check($sformatf("vec%0d_ovf", i), 32'(o), 32'(vecs[i].exp_ovf));
`endif
            step();
            check($sformatf("vec%0d_idle_valid", i), 32'(out_valid), 32'd0);
            check($sformatf("vec%0d_idle_ready", i), 32'(in_ready), 32'd1);
            out_ready = 1'b0;
        end

        // Consumer stalls in DONE; in_valid pulses must be ignored.
        run_word(8'h5A, 1'b0, res, lat, o);
        check("stall_latency", 32'(lat), 32'd8);
        for (int c = 0; c < 5; c++) begin
            in_valid = ~in_valid;
            in_data  = W'($urandom);
            step();
            check($sformatf("stall%0d_data", c), 32'(out_data), 32'hA6);
            check($sformatf("stall%0d_valid", c), 32'(out_valid), 32'd1);
            check($sformatf("stall%0d_ready", c), 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("stall_release_valid", 32'(out_valid), 32'd0);
        check("stall_release_ready", 32'(in_ready), 32'd1);
        check("stall_release_busy",  32'(busy), 32'd0);
        out_ready = 1'b0;

        // Asynchronous reset in the middle of SHIFT.
        in_valid = 1'b1;
        in_data  = 8'hFF;
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) step();
        #2 rst = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready",  32'(in_ready), 32'd1);
        check("abort_busy",      32'(busy), 32'd0);
        check("abort_out_data",  32'(out_data), 32'd0);
        step();
        rst = 1'b1;
        run_word(8'h03, 1'b1, res, lat, o);
        check("after_abort_latency", 32'(lat), 32'd8);
        check("after_abort_data", 32'(res), 32'hFD);
        step();
        out_ready = 1'b0;

        // Throughput with out_ready tied high: accepts every W+2 edges.
        begin
            int acc_cyc[$];
            int cyc;
            bit acc;
            cyc = 0;
            out_ready = 1'b1;
            in_valid  = 1'b1;
            while (acc_cyc.size() < 3 && cyc < 100) begin
                acc = in_valid && in_ready;
                in_data = W'($urandom);
                step();
                cyc++;
                if (acc) acc_cyc.push_back(cyc);
            end
            in_valid = 1'b0;
            check("tput_accepts", 32'(acc_cyc.size()), 32'd3);
            if (acc_cyc.size() == 3) begin
                check("tput_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'(W + 2));
                check("tput_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'(W + 2));
            end
            while (busy && cyc < 200) begin
                step();
                cyc++;
            end
            out_ready = 1'b0;
        end

        // Exhaustive operands back-to-back with random consumer backpressure.
        begin
            int  pend[$];
            int  x;
            int  got;
            int  cyc;
            bit  acc;
            bit  take;
            int  exp_x;
            x   = 0;
            got = 0;
            cyc = 0;
            while ((x < 256 || pend.size() != 0) && cyc < 20000) begin
                in_valid  = (x < 256);
                in_data   = W'(x);
                out_ready = 1'($urandom);
                acc  = in_valid && in_ready;
                take = out_valid && out_ready;
                if (take) begin
                    if (pend.size() == 0) begin
                        check("exh_unexpected_result", 32'(out_data), 32'hFFFF_FFFF);
                    end else begin
                        exp_x = pend.pop_front();
                        check($sformatf("exh_%0d", exp_x), 32'(out_data), 32'(ref_neg(exp_x)));
`ifdef TWOS_COMP_CTRL_OVF_EN
                        check($sformatf("exh_ovf_%0d", exp_x), 32'(ovf), 32'(exp_x == 128));
`endif
                        got++;
                    end
                end
                step();
                cyc++;
                if (acc) begin
                    pend.push_back(x);
                    x++;
                end
            end
            in_valid  = 1'b0;
            out_ready = 1'b0;
            check("exh_results", 32'(got), 32'd256);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
